// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED bank sequencer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package led_seq_pkg;

    localparam int LED_W = 8;

    localparam logic [LED_W-1:0] LED_OFF         = 8'h00;
    localparam logic [LED_W-1:0] LED_ALL         = 8'hFF;
    localparam logic [LED_W-1:0] LED_CHASE_START = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        WIN    = 2'd2,
        LOSE   = 2'd3
    } state_t;

    // Bar graph filling from the right: lvl 0 lights one LED, lvl 7 lights all eight.
    function automatic logic [LED_W-1:0] bar_pattern(input logic [2:0] lvl);
        return LED_ALL >> (3'd7 - lvl);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate generator: one-cycle tick every TICK_DIV cycles, restartable via clr.
// Latency: tick is a decode of the counter register; clr takes effect on the next edge.
// Backpressure: none; the tick is a free-running strobe.
module led_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int          CNT_W    = 26;
    localparam logic [25:0] CNT_LAST = 26'(TICK_DIV - 1);

    if (TICK_DIV < 2 || TICK_DIV > (2 ** CNT_W) - 1) begin : g_bad_tick_div
        $error("led_tick_gen: TICK_DIV must be in 2 .. 2^26-1");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    // Count up and wrap on the tick; a clear restarts the step so it lasts a full TICK_DIV.
    always_comb begin
        cnt_d = cnt_q + 26'd1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// 8-LED sequencer: charge bar graph, win blink, lose chase; lose > win > charge. Macro LED_ACTIVE_LOW_EN inverts led.
// Latency: every led/busy change is registered, one cycle after the causing request or tick.
// Backpressure: none; win requests during lose and requests of any kind are never queued.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 25000000,
    parameter int BLINK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_win,
    input  logic             req_lose,
    input  logic             charge_en,
    input  logic [2:0]       charge_lvl,
    output logic [LED_W-1:0] led,
    output logic             busy
);

    if (BLINK_CNT < 1 || BLINK_CNT > 15 || 2 * BLINK_CNT > 31) begin : g_bad_blink_cnt
        $error("led_sequencer: BLINK_CNT must be in 1 .. 15");
    end

    localparam logic [4:0] WIN_STEPS  = 5'(2 * BLINK_CNT);
    localparam logic [4:0] LOSE_STEPS = 5'(LED_W);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [LED_W-1:0] LED_POL = LED_ALL;
`else
    localparam logic [LED_W-1:0] LED_POL = LED_OFF;
`endif

    state_t           state_q, state_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [4:0]       step_q, step_d;
    logic [LED_W-1:0] led_q;
    logic             busy_q;
    logic             busy_d;
    logic             seq_clr;
    logic             tick;
    state_t           rest_state;
    logic [LED_W-1:0] rest_pat;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (seq_clr),
        .tick  (tick)
    );

    // Where a finished or non-sequence state settles: charge display if requested, else dark.
    always_comb begin
        rest_state = IDLE;
        rest_pat   = LED_OFF;
        if (charge_en) begin
            rest_state = CHARGE;
            rest_pat   = bar_pattern(charge_lvl);
        end
    end

    // Next-state logic: requests first by priority, then per-state pattern stepping on ticks.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        step_d  = step_q;
        seq_clr = 1'b0;

        if (req_lose) begin
            state_d = LOSE;
            pat_d   = LED_CHASE_START;
            step_d  = '0;
            seq_clr = 1'b1;
        end else if (req_win && state_q != LOSE) begin
            state_d = WIN;
            pat_d   = LED_ALL;
            step_d  = '0;
            seq_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, CHARGE: begin
                    state_d = rest_state;
                    pat_d   = rest_pat;
                end
                WIN: begin
                    if (tick) begin
                        step_d = step_q + 5'd1;
                        pat_d  = ~pat_q;
                        if (step_d == WIN_STEPS) begin
                            state_d = rest_state;
                            pat_d   = rest_pat;
                            step_d  = '0;
                        end
                    end
                end
                LOSE: begin
                    if (tick) begin
                        step_d = step_q + 5'd1;
                        pat_d  = pat_q >> 1;
                        if (step_d == LOSE_STEPS) begin
                            state_d = rest_state;
                            pat_d   = rest_pat;
                            step_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    pat_d   = LED_OFF;
                    step_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == WIN) || (state_d == LOSE);
    end

    // State and output registers; led is registered already in pin polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= LED_OFF;
            step_q  <= '0;
            led_q   <= LED_OFF ^ LED_POL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            step_q  <= step_d;
            led_q   <= pat_d ^ LED_POL;
            busy_q  <= busy_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer with TICK_DIV=4, BLINK_CNT=3.
// Latency: expectations are queued as stimulus is driven and checked just after the next edge.
// Backpressure: n/a.
module tb_led_sequencer;

    localparam int TD = 4;
    localparam int BC = 3;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       req_win    = 1'b0;
    logic       req_lose   = 1'b0;
    logic       charge_en  = 1'b0;
    logic [2:0] charge_lvl = 3'd0;
    logic [7:0] led;
    logic       busy;

    led_sequencer #(
        .TICK_DIV  (TD),
        .BLINK_CNT (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_win    (req_win),
        .req_lose   (req_lose),
        .charge_en  (charge_en),
        .charge_lvl (charge_lvl),
        .led        (led),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] led;
        logic       busy;
        string      nm;
    } exp_t;

    typedef struct {
        logic       ce;
        logic [2:0] lvl;
        logic [7:0] led;
        logic       busy;
    } cvec_t;

    exp_t  sb_q[$];
    cvec_t cv[8];
    int    checks   = 0;
    int    failures = 0;

    // Queue an expectation in active-high terms; pin polarity is applied here.
    task automatic push_exp(input logic [7:0] el, input logic eb, input string nm);
        exp_t e;
        e.led  = el ^ POL;
        e.busy = eb;
        e.nm   = nm;
        sb_q.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        if (led !== e.led || busy !== e.busy) begin
            failures++;
            $display("FAIL %s: got led=%h busy=%b, want led=%h busy=%b",
                     e.nm, led, busy, e.led, e.busy);
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input logic rw, input logic rl, input logic ce, input logic [2:0] lvl,
                       input logic [7:0] el, input logic eb, input string nm);
        @(negedge clk);
        req_win    = rw;
        req_lose   = rl;
        charge_en  = ce;
        charge_lvl = lvl;
        push_exp(el, eb, nm);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    initial begin : main
        logic [7:0] chase;
        logic [7:0] exp_led;
        chase = 8'h80;

        cv[0] = '{1'b1, 3'd0, 8'h01, 1'b0};
        cv[1] = '{1'b1, 3'd3, 8'h0F, 1'b0};
        cv[2] = '{1'b1, 3'd7, 8'hFF, 1'b0};
        cv[3] = '{1'b1, 3'd5, 8'h3F, 1'b0};
        cv[4] = '{1'b0, 3'd5, 8'h00, 1'b0};
        cv[5] = '{1'b0, 3'd7, 8'h00, 1'b0};
        cv[6] = '{1'b1, 3'd1, 8'h03, 1'b0};
        cv[7] = '{1'b0, 3'd1, 8'h00, 1'b0};

        // Reset held with random inputs, then release with no requests.
        for (int i = 0; i < 4; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 8'h00, 1'b0, "rst_hold");
        end
        req_win = 1'b0; req_lose = 1'b0; charge_en = 1'b0; charge_lvl = 3'd0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3'd0, 8'h00, 1'b0, "rst_idle");

        // Charge bar graph, table driven.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, cv[i].ce, cv[i].lvl, cv[i].led, cv[i].busy, $sformatf("chg_%0d", i));
        end

        // Win: 4-cycle steps, 6 ticks, busy for exactly 24 cycles.
        cyc(1, 0, 0, 3'd0, 8'hFF, 1'b1, "win_entry");
        for (int k = 1; k < 24; k++) begin
            exp_led = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
            cyc(0, 0, 0, 3'd0, exp_led, 1'b1, $sformatf("win_k%0d", k));
        end
        cyc(0, 0, 0, 3'd0, 8'h00, 1'b0, "win_exit");
        cyc(0, 0, 0, 3'd0, 8'h00, 1'b0, "win_after");

        // Lose chase with charge held; charge level changes while busy are ignored.
        cyc(0, 0, 1, 3'd2, 8'h07, 1'b0, "lose_pre_chg");
        cyc(0, 1, 1, 3'd2, 8'h80, 1'b1, "lose_entry");
        for (int k = 1; k < 32; k++) begin
            cyc(0, 0, 1, 3'd5, chase >> (k / 4), 1'b1, $sformatf("lose_k%0d", k));
        end
        cyc(0, 0, 1, 3'd2, 8'h07, 1'b0, "lose_exit_chg");
        cyc(0, 0, 0, 3'd2, 8'h00, 1'b0, "lose_to_idle");

        // Win preempted by lose 6 cycles in; lose gets a full first step.
        cyc(1, 0, 0, 3'd0, 8'hFF, 1'b1, "pre_win");
        for (int k = 1; k < 6; k++) begin
            exp_led = (((k / 4) % 2) == 0) ? 8'hFF : 8'h00;
            cyc(0, 0, 0, 3'd0, exp_led, 1'b1, $sformatf("pre_win_k%0d", k));
        end
        cyc(0, 1, 0, 3'd0, 8'h80, 1'b1, "pre_lose_entry");
        for (int k = 1; k < 10; k++) begin
            cyc((k == 5) ? 1'b1 : 1'b0, 0, 0, 3'd0, chase >> (k / 4), 1'b1,
                $sformatf("pre_lose_k%0d", k));
        end
        // Simultaneous requests: lose restarts, win is dropped.
        cyc(1, 1, 0, 3'd0, 8'h80, 1'b1, "both_req");
        for (int k = 1; k < 14; k++) begin
            cyc(0, 0, 0, 3'd0, chase >> (k / 4), 1'b1, $sformatf("both_k%0d", k));
        end

        // Asynchronous reset at lose step 3, then no resume after release.
        #2;
        rst_n = 1'b0;
        #1;
        push_exp(8'h00, 1'b0, "async_rst");
        compare_head();
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 3'd0, 8'h00, 1'b0, "mid_rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 3'd0, 8'h00, 1'b0, "no_resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller for the 8-LED bank. Sequences display patterns on game events: charge bar-graph, win blink, lose chase.
- Arbitrates between three requesters (lose, win, charge) with fixed priority.
- Sits between the game FSM and the board LED pins.
- Replaces free-running level-sensitive LED driving with a registered, clocked sequencer.

Parameters:
- TICK_DIV, 25000000, clock cycles per pattern step (250 ms at 100 MHz); legal range 2 to 2^26-1.
- BLINK_CNT, 3, number of on/off blink pairs in the win sequence; legal range 1 to 15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_win  in  1  single-cycle pulse: start win sequence.
- req_lose  in  1  single-cycle pulse: start lose sequence.
- charge_en  in  1  level: charge meter display requested.
- charge_lvl  in  3  charge level 0..7.
- led  out  8  LED drive, bit 7 leftmost.
- busy  out  1  high while a win or lose sequence is running.

Behaviour:
- Reset (async assert, sync release): state=IDLE, led=8'h00, busy=0, tick counter=0, step counter=0.
- All outputs are registered. Every led/busy change appears one cycle after the causing input edge or tick.
- Tick: an internal counter counts 0..TICK_DIV-1 and pulses tick when it wraps. The counter clears to 0 on every sequence start, so the first step lasts exactly TICK_DIV cycles.
- States: IDLE, CHARGE, WIN, LOSE.
- Priority: req_lose > req_win > charge_en.
- IDLE: led=8'h00.
  - req_lose -> LOSE.
  - else req_win -> WIN.
  - else charge_en -> CHARGE.
- CHARGE: led = (2^(charge_lvl+1))-1, so lvl 0 gives 8'h01 and lvl 7 gives 8'hFF. It tracks charge_lvl every cycle with no tick dependency.
  - charge_en low -> IDLE, led=8'h00 the next cycle.
  - req_win or req_lose preempt per priority.
- WIN: busy=1. Entry gives led=8'hFF and step=0.
  - Each tick: led toggles between 8'hFF and 8'h00, step++.
  - After 2*BLINK_CNT ticks: go to CHARGE if charge_en, else IDLE. busy=0 in the same cycle led leaves the pattern.
- LOSE: busy=1. Entry gives led=8'h80 and step=0.
  - Each tick: led shifts right by 1 (8'h80 -> 8'h40 -> ... -> 8'h01 -> 8'h00).
  - On the tick that produces 8'h00 (8th tick), exit as in WIN.
- Preemption:
  - req_lose during WIN aborts WIN and restarts LOSE (led=8'h80, tick counter cleared).
  - req_win during LOSE is dropped; no queueing.
  - A same-type request during an active sequence restarts it from step 0.
  - Simultaneous req_win and req_lose: LOSE wins and req_win is dropped.
- charge_en and charge_lvl are ignored while busy=1.
- Reset asserted mid-sequence returns immediately to the reset values. No sequence resumes after release.
- step counter is 5 bits wide. Width checks at elaboration: TICK_DIV fits 26 bits; 2*BLINK_CNT fits 5 bits.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
- Defined: led port is the bitwise inverse of the internal pattern, including reset (led=8'hFF after reset, 8'h7F at LOSE entry).
- Undefined: led is active-high, exactly as specified above.
- busy and all timing are unaffected either way.

Decomposition:
- Package led_seq_pkg holds:
  - state enum (IDLE, CHARGE, WIN, LOSE; 2 bits);
  - constants LED_OFF=8'h00, LED_ALL=8'hFF, LED_CHASE_START=8'h80, LED_W=8.
- Sub-module led_tick_gen (parameter TICK_DIV; ports clk, rst_n, clr, tick) is natural and reused by other timed display blocks.

Test Plan:
- Reset: hold rst_n=0, drive inputs randomly -> led=8'h00, busy=0 throughout. Release -> led stays 8'h00 with no requests.
- Charge: TICK_DIV=4, charge_en=1, charge_lvl 0,3,7 -> led=8'h01,8'h0F,8'hFF, each one cycle after the level change. charge_en=0 -> 8'h00.
- Win: TICK_DIV=4, BLINK_CNT=3, pulse req_win -> led 8'hFF for 4 cycles, alternating for 6 ticks total, then 8'h00. busy high for exactly 24 cycles.
- Lose chase with charge held: charge_en=1, lvl=2, pulse req_lose -> led 8'h80,8'h40,...,8'h01 at 4-cycle steps, then 8'h07 after the 8th tick. busy=0 on that cycle.
- Preemption: req_win, then req_lose 6 cycles later -> LOSE starts at 8'h80 with full 4-cycle first step. A later req_win during LOSE is ignored. req_win and req_lose in the same cycle -> LOSE.
- Mid-sequence reset: assert rst_n=0 at LOSE step 3 -> led=8'h00 and busy=0 asynchronously, with no resume after release. Rerun with LED_ACTIVE_LOW_EN defined -> led reset value 8'hFF, LOSE entry 8'h7F.
